// File: rtl/ysyx_041514_pipe_stage_hs_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_041514_pipe_stage_hs_pkg
// Shared definitions for the generic inter-stage pipeline register.
//   stage_state_e : stage occupancy encoding. The value equals the number of
//                   entries held, so it can be driven straight out as occupancy.
//   PS_STATE_W    : width of the stage-state register.
// -----------------------------------------------------------------------------
package ysyx_041514_pipe_stage_hs_pkg;

    localparam int PS_STATE_W = 2;

    typedef enum logic [PS_STATE_W-1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } stage_state_e;

endpackage

// File: rtl/ysyx_041514_pipe_stage_hs_reg.sv
// -----------------------------------------------------------------------------
// ysyx_041514_pipe_stage_hs_reg
// Plain register template with a synchronous active-high reset and a write
// enable. Used for the main, skid, valid/state and ready registers of a stage.
//   clk  : clock
//   rst  : synchronous reset, active-high (loads RESET_VAL)
//   wen  : load din on the next rising edge
//   din  : next value
//   dout : registered value
// -----------------------------------------------------------------------------
module ysyx_041514_pipe_stage_hs_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= RESET_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/ysyx_041514_pipe_stage_hs.sv
// -----------------------------------------------------------------------------
// ysyx_041514_pipe_stage_hs
// Generic valid/ready pipeline stage register carrying one packed payload.
//   SKID=1 : two-entry skid buffer, in_ready_o comes straight from a flop.
//   SKID=0 : single register, in_ready_o = !out_valid_o || out_ready_i.
// Empty entries always hold BUBBLE_VAL so consumers get decode-safe defaults.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   flush_i              : turn stage contents into a bubble next cycle
//   in_valid_i/in_ready_o/in_data_i    : upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o : downstream handshake and payload
//   occupancy_o          : entries held (0..2, 0..1 when SKID=0)
//   stall_cnt_o          : saturating count of out_valid_o && !out_ready_i
//   stall_cnt_clr_i      : synchronous clear of stall_cnt_o (beats increment)
// -----------------------------------------------------------------------------
module ysyx_041514_pipe_stage_hs
    import ysyx_041514_pipe_stage_hs_pkg::*;
#(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = {WIDTH{1'b0}},
    parameter bit               SKID       = 1'b1,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       occupancy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    input  logic             stall_cnt_clr_i
);

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    if (SKID) begin : g_skid
        logic [PS_STATE_W-1:0] state_raw;
        stage_state_e          state_q;
        stage_state_e          state_d;
        logic [WIDTH-1:0]      main_q, main_d, skid_q, skid_d;
        logic                  main_we, skid_we;
        logic                  ready_q, ready_d;

        assign state_q = stage_state_e'(state_raw);

        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            main_we = 1'b0;
            skid_d  = skid_q;
            skid_we = 1'b0;

            if (flush_i) begin
                // Any concurrent in_fire is swallowed; an out_fire has
                // already been taken by downstream this cycle.
                state_d = PS_EMPTY;
                main_d  = BUBBLE_VAL;
                main_we = 1'b1;
                skid_d  = BUBBLE_VAL;
                skid_we = 1'b1;
            end else begin
                case (state_q)
                    PS_EMPTY: begin
                        if (in_fire) begin
                            main_d  = in_data_i;
                            main_we = 1'b1;
                            state_d = PS_BUSY;
                        end
                    end
                    PS_BUSY: begin
                        if (in_fire && out_fire) begin
                            main_d  = in_data_i;
                            main_we = 1'b1;
                        end else if (out_fire) begin
                            main_d  = BUBBLE_VAL;
                            main_we = 1'b1;
                            state_d = PS_EMPTY;
                        end else if (in_fire) begin
                            skid_d  = in_data_i;
                            skid_we = 1'b1;
                            state_d = PS_FULL;
                        end
                    end
                    PS_FULL: begin
                        // in_ready_o is low here, so only the drain is possible.
                        if (out_fire) begin
                            main_d  = skid_q;
                            main_we = 1'b1;
                            skid_d  = BUBBLE_VAL;
                            skid_we = 1'b1;
                            state_d = PS_BUSY;
                        end
                    end
                    default: begin
                        state_d = PS_EMPTY;
                        main_d  = BUBBLE_VAL;
                        main_we = 1'b1;
                        skid_d  = BUBBLE_VAL;
                        skid_we = 1'b1;
                    end
                endcase
            end
        end

        // Ready is registered from the next state, cutting the out_ready_i path.
        assign ready_d = (state_d != PS_FULL);

        ysyx_041514_pipe_stage_hs_reg #(.WIDTH(PS_STATE_W), .RESET_VAL(PS_EMPTY)) u_state (
            .clk(clk), .rst(rst), .wen(1'b1), .din(state_d), .dout(state_raw)
        );
        ysyx_041514_pipe_stage_hs_reg #(.WIDTH(WIDTH), .RESET_VAL(BUBBLE_VAL)) u_main (
            .clk(clk), .rst(rst), .wen(main_we), .din(main_d), .dout(main_q)
        );
        ysyx_041514_pipe_stage_hs_reg #(.WIDTH(WIDTH), .RESET_VAL(BUBBLE_VAL)) u_skid (
            .clk(clk), .rst(rst), .wen(skid_we), .din(skid_d), .dout(skid_q)
        );
        ysyx_041514_pipe_stage_hs_reg #(.WIDTH(1), .RESET_VAL(1'b1)) u_ready (
            .clk(clk), .rst(rst), .wen(1'b1), .din(ready_d), .dout(ready_q)
        );

        assign in_ready_o  = ready_q;
        assign out_valid_o = (state_q != PS_EMPTY);
        assign out_data_o  = main_q;
        assign occupancy_o = state_raw;
    end else begin : g_direct
        logic             valid_q, valid_d;
        logic [WIDTH-1:0] main_q, main_d;
        logic             main_we;

        always_comb begin
            valid_d = valid_q;
            main_d  = main_q;
            main_we = 1'b0;
            if (flush_i) begin
                valid_d = 1'b0;
                main_d  = BUBBLE_VAL;
                main_we = 1'b1;
            end else if (in_fire) begin
                valid_d = 1'b1;
                main_d  = in_data_i;
                main_we = 1'b1;
            end else if (out_fire) begin
                valid_d = 1'b0;
                main_d  = BUBBLE_VAL;
                main_we = 1'b1;
            end
        end

        ysyx_041514_pipe_stage_hs_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid (
            .clk(clk), .rst(rst), .wen(1'b1), .din(valid_d), .dout(valid_q)
        );
        ysyx_041514_pipe_stage_hs_reg #(.WIDTH(WIDTH), .RESET_VAL(BUBBLE_VAL)) u_main (
            .clk(clk), .rst(rst), .wen(main_we), .din(main_d), .dout(main_q)
        );

        assign in_ready_o  = !valid_q || out_ready_i;
        assign out_valid_o = valid_q;
        assign out_data_o  = main_q;
        assign occupancy_o = {1'b0, valid_q};
    end

    // Back-pressure counter: clear beats increment, and it sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stall_cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ysyx_041514_pipe_stage_hs.sv
// -----------------------------------------------------------------------------
// tb_ysyx_041514_pipe_stage_hs
// Drives one skid-mode stage and one direct-mode stage with the same inputs and
// compares both against queue-based reference models every cycle.
// -----------------------------------------------------------------------------
module tb_ysyx_041514_pipe_stage_hs;

    localparam int         W       = 8;
    localparam int         CW      = 4;
    localparam int         CNT_MAX = 15;
    localparam logic [7:0] BUB_A   = 8'h00;
    localparam logic [7:0] BUB_B   = 8'hE5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, flush, in_valid, out_ready, clr;
    logic [W-1:0] in_data;

    logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [W-1:0]  a_out_data, b_out_data;
    logic [1:0]    a_occ, b_occ;
    logic [CW-1:0] a_cnt, b_cnt;

    ysyx_041514_pipe_stage_hs #(.WIDTH(W), .BUBBLE_VAL(BUB_A), .SKID(1'b1), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
        .occupancy_o(a_occ), .stall_cnt_o(a_cnt), .stall_cnt_clr_i(clr)
    );

    ysyx_041514_pipe_stage_hs #(.WIDTH(W), .BUBBLE_VAL(BUB_B), .SKID(1'b0), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
        .occupancy_o(b_occ), .stall_cnt_o(b_cnt), .stall_cnt_clr_i(clr)
    );

    int tests = 0;
    int fails = 0;
    bit started = 1'b0;

    // Reference state: FIFO contents (head = output), registered ready for A,
    // and stall counters.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         rdy_a = 1'b1;
    int         cnt_a = 0;
    int         cnt_b = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit fl, input bit v, input logic [7:0] d,
                         input bit ordy, input bit cl);
        rst = r; flush = fl; in_valid = v; in_data = d; out_ready = ordy; clr = cl;
    endtask

    task automatic cycle();
        bit a_in_f, a_out_f, b_in_f, b_out_f, b_rdy;
        logic [7:0] ea, eb;
        #1;
        b_rdy = (qb.size() == 0) || out_ready;
        if (started) begin
            check("A.in_ready_pre", 32'(a_in_ready), 32'(rdy_a));
            check("B.in_ready_comb", 32'(b_in_ready), 32'(b_rdy));
        end
        a_in_f  = in_valid && rdy_a;
        a_out_f = (qa.size() != 0) && out_ready;
        b_in_f  = in_valid && b_rdy;
        b_out_f = (qb.size() != 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            qa.delete(); qb.delete();
            rdy_a = 1'b1; cnt_a = 0; cnt_b = 0;
        end else begin
            if (clr) cnt_a = 0;
            else if (qa.size() != 0 && !out_ready && cnt_a < CNT_MAX) cnt_a++;
            if (clr) cnt_b = 0;
            else if (qb.size() != 0 && !out_ready && cnt_b < CNT_MAX) cnt_b++;
            if (flush) begin
                qa.delete(); qb.delete();
            end else begin
                if (a_out_f) void'(qa.pop_front());
                if (a_in_f)  qa.push_back(in_data);
                if (b_out_f) void'(qb.pop_front());
                if (b_in_f)  qb.push_back(in_data);
            end
            rdy_a = (qa.size() < 2);
        end
        started = 1'b1;
        #1;
        ea = (qa.size() != 0) ? qa[0] : BUB_A;
        eb = (qb.size() != 0) ? qb[0] : BUB_B;
        check("A.out_valid", 32'(a_out_valid), 32'(qa.size() != 0));
        check("A.out_data",  32'(a_out_data),  32'(ea));
        check("A.occupancy", 32'(a_occ),       32'(qa.size()));
        check("A.stall_cnt", 32'(a_cnt),       32'(cnt_a));
        check("A.in_ready",  32'(a_in_ready),  32'(rdy_a));
        check("B.out_valid", 32'(b_out_valid), 32'(qb.size() != 0));
        check("B.out_data",  32'(b_out_data),  32'(eb));
        check("B.occupancy", 32'(b_occ),       32'(qb.size()));
        check("B.stall_cnt", 32'(b_cnt),       32'(cnt_b));
        @(negedge clk);
    endtask

    initial begin
        drive(1, 0, 1, 8'hFF, 1, 0);
        @(negedge clk);
        // Reset with in_valid high: the beat must be ignored.
        cycle(); cycle();

        // Stream 0x11, 0x22, 0x33 with downstream always ready.
        drive(0, 0, 1, 8'h11, 1, 0); cycle();
        drive(0, 0, 1, 8'h22, 1, 0); cycle();
        drive(0, 0, 1, 8'h33, 1, 0); cycle();
        drive(0, 0, 0, 8'h00, 1, 0); cycle(); cycle();

        // Back-pressure fills the skid entry; then release and drain in order.
        drive(0, 0, 1, 8'hA1, 0, 0); cycle();
        drive(0, 0, 1, 8'hA2, 0, 0); cycle();
        drive(0, 0, 0, 8'h00, 0, 0); repeat (3) cycle();
        drive(0, 0, 0, 8'h00, 1, 0); repeat (3) cycle();

        // Flush while full with a concurrent beat 0x77 that must be discarded.
        drive(0, 0, 1, 8'hC1, 0, 0); cycle();
        drive(0, 0, 1, 8'hC2, 0, 0); cycle();
        drive(0, 1, 1, 8'h77, 0, 0); cycle();
        drive(0, 0, 0, 8'h00, 1, 0); repeat (2) cycle();

        // Stall counter saturation at 15, then clear and resume counting.
        drive(0, 0, 1, 8'hD1, 0, 0); cycle();
        drive(0, 0, 0, 8'h00, 0, 0); repeat (20) cycle();
        drive(0, 0, 0, 8'h00, 0, 1); cycle();
        drive(0, 0, 0, 8'h00, 0, 0); repeat (2) cycle();

        // Direct mode: ready follows out_ready_i within the cycle, and 0x5C
        // replaces the held beat without a bubble.
        drive(0, 0, 1, 8'h5C, 0, 0); cycle();
        drive(0, 0, 1, 8'h5C, 1, 0); cycle();
        drive(0, 0, 0, 8'h00, 1, 0); repeat (3) cycle();

        // Reset while full, with in_valid high during reset.
        drive(0, 0, 1, 8'hB1, 0, 0); cycle();
        drive(0, 0, 1, 8'hB2, 0, 0); cycle();
        drive(1, 0, 1, 8'hB3, 0, 0); cycle();
        drive(0, 0, 0, 8'h00, 1, 0); repeat (2) cycle();

        // Random traffic with occasional flush, clear and reset.
        repeat (400) begin
            drive($urandom_range(63) == 0, $urandom_range(15) == 0,
                  $urandom_range(9) < 6, 8'($urandom),
                  $urandom_range(9) < 6, $urandom_range(31) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_041514_pipe_stage_hs.md
Name: ysyx_041514_pipe_stage_hs

Overview:
- Generic, parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) that replaces per-field hand-built stage registers.
- Carries one packed payload bus with valid/ready handshake, synchronous flush-to-bubble, and an optional 2-entry skid mode that breaks the ready path.
- Adds a saturating back-pressure counter for performance counters.

Parameters:
- WIDTH, 64, payload width in bits (packed pc/inst/rd/imm/op/trap fields).
- BUBBLE_VAL, {WIDTH{1'b0}}, payload driven on reset, flush and empty; packer places INST_NOP and the *_NONE opcodes here.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready_o; 0 = single register with combinational ready.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  kill stage contents this cycle
- in_valid_i  in  1  upstream payload valid
- in_ready_o  out  1  stage can accept
- in_data_i  in  WIDTH  upstream payload
- out_valid_o  out  1  downstream payload valid
- out_ready_i  in  1  downstream accepts
- out_data_o  out  WIDTH  downstream payload (main register)
- occupancy_o  out  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt_o  out  CNT_W  cycles with out_valid_o && !out_ready_i, saturating
- stall_cnt_clr_i  in  1  synchronous clear of stall_cnt_o

Behaviour:
- Handshakes: in_fire = in_valid_i && in_ready_o; out_fire = out_valid_o && out_ready_i. Payload moves only on a fire. out_data_o is stable while out_valid_o && !out_ready_i.
- Reset (rst high at clock edge):
  - out_valid_o=0, out_data_o=BUBBLE_VAL, skid empty, occupancy_o=0, stall_cnt_o=0.
  - in_ready_o=1 from the cycle after reset.
  - in_valid_i is ignored in any cycle rst is high.
- SKID=1 state machine (state = occupancy):
  - EMPTY: in_fire -> main<=in, BUSY.
  - BUSY:
    - in_fire && out_fire -> main<=in, stay BUSY.
    - out_fire only -> EMPTY, main<=BUBBLE_VAL.
    - in_fire only -> skid<=in, FULL.
  - FULL:
    - out_fire -> main<=skid, skid cleared, BUSY.
    - in_ready_o=0, so no in_fire is possible.
  - in_ready_o is a register equal to (next state != FULL). It has no combinational path from out_ready_i.
  - Latency: 1 cycle in_fire -> out_valid_o. Throughput: 1/cycle under continuous ready.
- SKID=0:
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - in_fire -> main<=in, out_valid_o=1 next cycle.
  - out_fire without in_fire -> out_valid_o=0, main<=BUBBLE_VAL.
  - occupancy_o is 0 or 1.
- Flush (flush_i=1):
  - Priority: rst > flush > normal.
  - Next cycle: out_valid_o=0, main and skid <= BUBBLE_VAL, occupancy_o=0.
  - A concurrent in_fire is consumed and discarded.
  - A concurrent out_fire still completes; the downstream owns that beat.
  - in_ready_o=1 in the cycle after flush.
  - stall_cnt_o is unaffected by flush.
- Stall counter:
  - Increments by 1 each cycle out_valid_o && !out_ready_i && !rst.
  - Holds at all-ones (no wrap).
  - stall_cnt_clr_i zeroes it next cycle and has priority over increment.
- Data never reorders: FIFO order main -> skid.
- Empty entries hold BUBBLE_VAL, so consumers may ignore valid for decode-safe defaults.

Decomposition:
- Shared package/header (sysconfig): stage-state encodings PS_EMPTY=2'd0, PS_BUSY=2'd1, PS_FULL=2'd2, and per-stage payload width macros.
- BUBBLE_VAL composites (NOP + *_NONE + zero trap bus) are built in the stage packers, not in this block.
- One natural sub-module: the existing ysyx_041514_regTemplate, instantiated for the main, skid and valid registers with computed wen/din.

Test Plan:
- Reset then stream, SKID=1, WIDTH=8, out_ready_i=1: after rst, drive 0x11,0x22,0x33 on consecutive cycles -> out_data_o shows 0x11,0x22,0x33 one cycle later each, with in_ready_o=1 and occupancy_o<=1 throughout.
- Back-pressure/skid fill: hold out_ready_i=0, send 0xA1,0xA2 -> occupancy_o=2, in_ready_o=0, out_data_o=0xA1 stable, stall_cnt_o counts 1,2,3…. Release ready -> 0xA1 then 0xA2 in order, occupancy_o returns to 0.
- Flush in FULL with simultaneous in_valid_i=1 (0x77): next cycle out_valid_o=0, out_data_o=BUBBLE_VAL, occupancy_o=0, in_ready_o=1, and 0x77 never appears at the output.
- Stall counter saturation, CNT_W=4: hold out_valid_o=1, out_ready_i=0 for 20 cycles -> stall_cnt_o=15 and stays there. Pulse stall_cnt_clr_i -> 0 next cycle, then 1 after.
- SKID=0 mode: out_ready_i=0 with out_valid_o=1 -> in_ready_o=0 in the same cycle. Set out_ready_i=1 -> in_ready_o=1 combinationally, and a new beat 0x5C replaces the old beat with no bubble.
- Reset mid-operation: rst asserted while FULL (0xB1,0xB2) -> next cycle out_valid_o=0, occupancy_o=0, stall_cnt_o=0, out_data_o=BUBBLE_VAL, and in_valid_i during rst is ignored.
